pc_fetch_unit: RTL

//  Fetch-stage program counter. Holds the PC and sends it to instruction memory.

---
 rtl/pc_fetch_unit.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit
// ----------------------------------------------------------------------------
// Fetch-stage program counter. Holds the PC and presents it to instruction
// memory. Applies the redirect chosen by the EX-stage branch/jump resolver.
// Squashes wrong-path IF/ID and ID/EX entries. Buffers a redirect that arrives
// while imem is busy. Traps, sticky until reset, on a misaligned target.
//
// Ports
//   clk_i          in   1      clock, rising edge
//   rst_n_i        in   1      asynchronous active-low reset
//   pc_src_i       in   2      0=PC+4, 1=pc_target_i, 2=JALR, 3=treated as 0
//   pc_target_i    in   XLEN   branch/JAL target
//   alu_result_i   in   XLEN   JALR target before bit0 clear
//   stall_i        in   1      hazard-unit hold
//   imem_ready_i   in   1      imem accepts pc_o this cycle
//   pc_o           out  XLEN   current fetch address
//   pc_plus4_o     out  XLEN   pc_o + 4 (wraps)
//   imem_req_o     out  1      fetch request valid
//   flush_ifid_o   out  1      squash IF/ID at next edge
//   flush_idex_o   out  1      squash ID/EX at next edge
//   misalign_o     out  1      sticky misaligned-target trap
//   redirect_cnt_o out  CNT_W  saturating count of taken redirects
// ============================================================================
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [1:0]       pc_src_i,
    input  logic [XLEN-1:0]  pc_target_i,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic             imem_req_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_RDIR_WAIT = 2'd1,
        ST_TRAP      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic              pend_vld_q, pend_vld_d;
    logic              misalign_q, misalign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   tgt;
    logic [XLEN-1:0]   pc_plus4;
    logic [CNT_W-1:0]  cnt_inc;
    logic              redir;
    logic              bad;
    logic              req_raw;
    logic              flush_ifid_raw;
    logic              flush_idex_raw;

    // Target selection and alignment check
    always_comb begin
        tgt      = (pc_src_i == 2'd1) ? pc_target_i
                                      : (alu_result_i & ~XLEN'(1));
        redir    = (pc_src_i == 2'd1) || (pc_src_i == 2'd2);
        bad      = redir && (tgt[1:0] != 2'b00);
        pc_plus4 = pc_q + XLEN'(4);
        cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_pc_d      = pend_pc_q;
        pend_vld_d     = pend_vld_q;
        misalign_d     = misalign_q;
        cnt_d          = cnt_q;
        req_raw        = 1'b0;
        flush_ifid_raw = 1'b0;
        flush_idex_raw = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                req_raw = 1'b1;
                if (bad) begin
                    misalign_d = 1'b1;
                    state_d    = ST_TRAP;
                end else if (redir) begin
                    // Redirect takes priority over a hazard stall
                    flush_ifid_raw = 1'b1;
                    flush_idex_raw = 1'b1;
                    cnt_d          = cnt_inc;
                    if (imem_ready_i) begin
                        pc_d = tgt;
                    end else begin
                        pend_pc_d  = tgt;
                        pend_vld_d = 1'b1;
                        state_d    = ST_RDIR_WAIT;
                    end
                end else if (imem_ready_i && !stall_i) begin
                    pc_d = pc_plus4;
                end
            end
            ST_RDIR_WAIT: begin
                // The fetch of the old pc_o is still in flight
                req_raw = 1'b1;
                if (bad) begin
                    misalign_d = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = ST_TRAP;
                end else if (redir) begin
                    // Latest redirect replaces the buffered one
                    flush_ifid_raw = 1'b1;
                    flush_idex_raw = 1'b1;
                    cnt_d          = cnt_inc;
                    pend_pc_d      = tgt;
                    if (imem_ready_i) begin
                        pc_d       = tgt;
                        pend_vld_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end else if (imem_ready_i && pend_vld_q) begin
                    // Instruction returned now is from the wrong path
                    flush_ifid_raw = 1'b1;
                    pc_d           = pend_pc_q;
                    pend_vld_d     = 1'b0;
                    state_d        = ST_RUN;
                end
            end
            ST_TRAP: begin
                // Frozen until reset
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            pend_vld_q <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_vld_q <= pend_vld_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // Request and flushes are forced low for as long as reset is held
    assign imem_req_o     = rst_n_i & req_raw;
    assign flush_ifid_o   = rst_n_i & flush_ifid_raw;
    assign flush_idex_o   = rst_n_i & flush_idex_raw;
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4;
    assign misalign_o     = misalign_q;
    assign redirect_cnt_o = cnt_q;

endmodule
